// File: rtl/aes_decode_core.sv
// rtl/aes_decode_core.sv - iterative AES-128 inverse cipher behind a byte-wide host buffer interface
//
// Purpose: decrypts one 128-bit block per operation, one round per clock. It first expands
// the key forward to round key 10, then walks the key schedule backwards one key per round.
//
// Ports:
//   iCLK   in   1  clock, rising edge
//   iRST   in   1  synchronous active-high reset
//   iDATA  in   8  write data for the ciphertext/key buffers
//   iADDR  in   4  byte index; byte 0 = bits [127:120]
//   iWR    in   1  write iDATA to ciphertext buffer[iADDR]
//   iKWR   in   1  write iDATA to key buffer[iADDR]
//   iRD    in   1  read request, oDATA <= out_block[iADDR] on the next edge
//   iDEC   in   1  start decryption (accepted only when idle)
//   oBUSY  out  1  operation in progress
//   oDONE  out  1  one-cycle pulse when out_block is updated
//   oDATA  out  8  registered read data
module aes_decode_core #(
  parameter logic [127:0] DEFAULT_KEY = 128'h00112233445566778899aabbccddeeff
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic [3:0] iADDR,
  input  logic       iWR,
  input  logic       iKWR,
  input  logic       iRD,
  input  logic       iDEC,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [7:0] oDATA
);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ADD0, S_ROUND, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Table entry x sits at bits [8*(255-x) +: 8]; 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    inv_sbox = INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    mul9 = xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    mulb = xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    muld = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    mule = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_in;
  logic [127:0] r_key;
  logic [127:0] r_out;
  logic [127:0] r_state;
  logic [127:0] r_kreg;
  logic [3:0]   r_rc;
  logic         r_busy;
  logic         r_done;
  logic [7:0]   r_rdata;

  assign oBUSY = r_busy;
  assign oDONE = r_done;
  assign oDATA = r_rdata;

  // ---------------- key path ----------------
  logic [31:0]  w_kw0, w_kw1, w_kw2, w_kw3;
  logic [31:0]  w_inv1, w_inv2, w_inv3;
  logic [31:0]  w_sub_in, w_sub;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [127:0] w_kfwd;
  logic [127:0] w_kinv;

  assign {w_kw0, w_kw1, w_kw2, w_kw3} = r_kreg;

  // Columns 3..1 of the previous round key fall out of neighbouring XORs.
  assign w_inv3 = w_kw3 ^ w_kw2;
  assign w_inv2 = w_kw2 ^ w_kw1;
  assign w_inv1 = w_kw1 ^ w_kw0;

  // One SubWord(RotWord()) unit serves both directions: forward expansion feeds it the
  // current column 3, the inverse schedule feeds it the recovered previous column 3.
  assign w_sub_in = (r_fsm == S_ROUND) ? w_inv3 : w_kw3;
  assign w_sub = {sbox(w_sub_in[23:16]), sbox(w_sub_in[15:8]),
                  sbox(w_sub_in[7:0]),   sbox(w_sub_in[31:24])} ^ {rcon(r_rc), 24'h000000};

  assign w_f0   = w_kw0 ^ w_sub;
  assign w_f1   = w_kw1 ^ w_f0;
  assign w_f2   = w_kw2 ^ w_f1;
  assign w_f3   = w_kw3 ^ w_f2;
  assign w_kfwd = {w_f0, w_f1, w_f2, w_f3};
  assign w_kinv = {w_kw0 ^ w_sub, w_inv1, w_inv2, w_inv3};

  // ---------------- data path ----------------
  logic [127:0] w_sb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_ark = w_sb ^ w_kinv;

  for (genvar c = 0; c < 4; c++) begin : g_col
    // InvShiftRows moves row r right by r columns, so output (r,c) reads input (r,c-r).
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sb[127 - 8*(4*c + r) -: 8] =
        inv_sbox(r_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
    end

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = w_ark[127 - 32*c -: 32];
    assign w_imc[127 - 32*c -: 32] = {
      mule(w_a0) ^ mulb(w_a1) ^ muld(w_a2) ^ mul9(w_a3),
      mul9(w_a0) ^ mule(w_a1) ^ mulb(w_a2) ^ muld(w_a3),
      muld(w_a0) ^ mul9(w_a1) ^ mule(w_a2) ^ mulb(w_a3),
      mulb(w_a0) ^ muld(w_a1) ^ mul9(w_a2) ^ mule(w_a3)
    };
  end

  // ---------------- control ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (iDEC) w_fsm_nxt = S_KEXP;
      S_KEXP:  if (r_rc == 4'd10) w_fsm_nxt = S_ADD0;
      S_ADD0:  w_fsm_nxt = S_ROUND;
      S_ROUND: if (r_rc == 4'd1) w_fsm_nxt = S_DONE;
      S_DONE:  w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_in    <= '0;
      r_key   <= DEFAULT_KEY;
      r_out   <= '0;
      r_state <= '0;
      r_kreg  <= '0;
      r_rc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      if (iWR)  r_in[{~iADDR, 3'b000} +: 8]  <= iDATA;
      if (iKWR) r_key[{~iADDR, 3'b000} +: 8] <= iDATA;
      if (iRD)  r_rdata <= r_out[{~iADDR, 3'b000} +: 8];
      r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          // Buffers are sampled before any same-cycle write lands.
          if (iDEC) begin
            r_state <= r_in;
            r_kreg  <= r_key;
            r_rc    <= 4'd1;
            r_busy  <= 1'b1;
          end
        end
        S_KEXP: begin
          r_kreg <= w_kfwd;
          // rc stays at 10 so the first inverse round uses Rcon[10].
          if (r_rc != 4'd10) r_rc <= r_rc + 4'd1;
        end
        S_ADD0: r_state <= r_state ^ r_kreg;
        S_ROUND: begin
          r_kreg  <= w_kinv;
          r_rc    <= r_rc - 4'd1;
          r_state <= (r_rc == 4'd1) ? w_ark : w_imc;
        end
        S_DONE: begin
          r_out  <= r_state;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decode_core.sv
// tb/tb_aes_decode_core.sv - self-checking bench for aes_decode_core
module tb_aes_decode_core;

  localparam logic [127:0] DEF_KEY = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;

  logic       iCLK;
  logic       iRST;
  logic [7:0] iDATA;
  logic [3:0] iADDR;
  logic       iWR;
  logic       iKWR;
  logic       iRD;
  logic       iDEC;
  logic       oBUSY;
  logic       oDONE;
  logic [7:0] oDATA;

  int n_checks;
  int n_errors;

  logic [7:0] m_sbox  [256];
  logic [7:0] m_isbox [256];

  int b2b_cyc;
  int b2b_done[$];

  aes_decode_core #(.DEFAULT_KEY(DEF_KEY)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iDATA(iDATA),
    .iADDR(iADDR),
    .iWR  (iWR),
    .iKWR (iKWR),
    .iRD  (iRD),
    .iDEC (iDEC),
    .oBUSY(oBUSY),
    .oDONE(oDONE),
    .oDATA(oDATA)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic init_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, inv, s;
      xb = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      m_sbox[x] = s;
      m_isbox[s] = xb;
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcv;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]], m_sbox[t[31:24]]} ^ {rcv, 24'h0};
        rcv = gmul(rcv, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = ct[127 - 8*j -: 8] ^ w[40 + j/4][31 - 8*(j%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int j = 0; j < 16; j++)
        u[j] = m_isbox[s[4*((j/4 - j%4 + 4) % 4) + j%4]] ^ w[4*r + j/4][31 - 8*(j%4) -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end else begin
        s = u;
      end
    end
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
    return res;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic write_block(input logic [127:0] b);
    for (int i = 0; i < 16; i++) begin
      iWR = 1'b1; iADDR = i[3:0]; iDATA = b[127 - 8*i -: 8];
      tick();
    end
    iWR = 1'b0;
  endtask

  task automatic write_key(input logic [127:0] k);
    for (int i = 0; i < 16; i++) begin
      iKWR = 1'b1; iADDR = i[3:0]; iDATA = k[127 - 8*i -: 8];
      tick();
    end
    iKWR = 1'b0;
  endtask

  task automatic read_block(output logic [127:0] b);
    b = '0;
    for (int i = 0; i < 16; i++) begin
      iRD = 1'b1; iADDR = i[3:0];
      tick();
      b[127 - 8*i -: 8] = oDATA;
    end
    iRD = 1'b0;
  endtask

  // Pulses iDEC (edge E0) and watches 40 further edges.
  task automatic run_dec(output logic busy1, output int first, output int nd);
    iDEC = 1'b1;
    tick();
    iDEC = 1'b0;
    busy1 = oBUSY;
    first = -1;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (oDONE) begin
        nd++;
        if (first < 0) first = c;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iRST = 1'b1;
    tick();
    tick();
    n_checks++;
    if (oBUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", oBUSY); end
    n_checks++;
    if (oDONE !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", oDONE); end
    n_checks++;
    if (oDATA !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", oDATA); end
    iRST = 1'b0;
    iRD = 1'b1; iADDR = 4'd7;
    tick();
    iRD = 1'b0;
    n_checks++;
    if (oDATA !== 8'h00) begin n_errors++; $display("FAIL reset_read7: got %h expected 00", oDATA); end
  endtask

  task automatic test_vector(input string name, input logic [127:0] key,
                             input logic [127:0] ct, input logic [127:0] pt);
    logic busy1;
    int first, nd;
    logic [127:0] got;
    write_key(key);
    write_block(ct);
    run_dec(busy1, first, nd);
    read_block(got);
    n_checks++;
    if (busy1 !== 1'b1) begin n_errors++; $display("FAIL %s_busy: got %b expected 1", name, busy1); end
    n_checks++;
    if (first !== 22) begin n_errors++; $display("FAIL %s_latency: got %0d expected 22", name, first); end
    n_checks++;
    if (nd !== 1) begin n_errors++; $display("FAIL %s_done_count: got %0d expected 1", name, nd); end
    n_checks++;
    if (got !== pt) begin n_errors++; $display("FAIL %s_result: got %h expected %h", name, got, pt); end
  endtask

  task automatic test_isolation();
    int first, nd;
    logic busy1;
    logic [127:0] got, newk, newc, exp2;
    write_key(KEY_B);
    write_block(CT_B);
    iDEC = 1'b1;
    tick();
    first = -1;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      iDEC  = (c == 5);
      iWR   = (c == 6);
      iKWR  = (c == 7);
      iADDR = 4'd0;
      iDATA = (c == 6) ? 8'hff : 8'h00;
      tick();
      if (oDONE) begin
        nd++;
        if (first < 0) first = c;
      end
    end
    iDEC = 1'b0; iWR = 1'b0; iKWR = 1'b0;
    read_block(got);
    n_checks++;
    if (nd !== 1) begin n_errors++; $display("FAIL iso_done_count: got %0d expected 1", nd); end
    n_checks++;
    if (first !== 22) begin n_errors++; $display("FAIL iso_latency: got %0d expected 22", first); end
    n_checks++;
    if (got !== PT_B) begin n_errors++; $display("FAIL iso_result: got %h expected %h", got, PT_B); end
    newk = KEY_B; newk[127:120] = 8'h00;
    newc = CT_B;  newc[127:120] = 8'hff;
    exp2 = model_decrypt(newk, newc);
    run_dec(busy1, first, nd);
    read_block(got);
    n_checks++;
    if (got !== exp2) begin n_errors++; $display("FAIL iso_next_result: got %h expected %h", got, exp2); end
    n_checks++;
    if (got === PT_B) begin n_errors++; $display("FAIL iso_next_differs: got %h expected not %h", got, PT_B); end
  endtask

  task automatic test_reset_midop();
    int nd, first;
    logic busy1;
    logic [127:0] got, exp0;
    write_key(KEY_B);
    write_block(CT_B);
    iDEC = 1'b1;
    tick();
    iDEC = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    n_checks++;
    if (oBUSY !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b expected 0", oBUSY); end
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (oDONE) nd++;
    end
    n_checks++;
    if (nd !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d expected 0", nd); end
    read_block(got);
    n_checks++;
    if (got !== 128'h0) begin n_errors++; $display("FAIL midrst_out_zero: got %h expected 0", got); end
    // Both buffers are back at reset values: zero ciphertext under the default key.
    exp0 = model_decrypt(DEF_KEY, 128'h0);
    run_dec(busy1, first, nd);
    read_block(got);
    n_checks++;
    if (got !== exp0) begin n_errors++; $display("FAIL midrst_default_key: got %h expected %h", got, exp0); end
    test_vector("midrst_rerun", KEY_B, CT_B, PT_B);
  endtask

  task automatic b2b_step(input logic rd, input logic [3:0] a);
    iDEC  = (b2b_cyc + 1 < 60);
    iRD   = rd;
    iADDR = a;
    tick();
    b2b_cyc++;
    if (oDONE) b2b_done.push_back(b2b_cyc);
  endtask

  task automatic test_back_to_back();
    logic [127:0] r1, r2;
    int d0, d1, d2;
    write_key(KEY_B);
    write_block(CT_B);
    b2b_cyc = -1;
    b2b_done.delete();
    r1 = '0; r2 = '0;
    b2b_step(1'b0, 4'd0);
    while (b2b_done.size() < 1 && b2b_cyc < 40) b2b_step(1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      b2b_step(1'b1, i[3:0]);
      r1[127 - 8*i -: 8] = oDATA;
    end
    while (b2b_done.size() < 2 && b2b_cyc < 80) b2b_step(1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      b2b_step(1'b1, i[3:0]);
      r2[127 - 8*i -: 8] = oDATA;
    end
    while (b2b_cyc < 75) b2b_step(1'b0, 4'd0);
    iDEC = 1'b0; iRD = 1'b0;
    d0 = (b2b_done.size() > 0) ? b2b_done[0] : -1;
    d1 = (b2b_done.size() > 1) ? b2b_done[1] : -1;
    d2 = (b2b_done.size() > 2) ? b2b_done[2] : -1;
    n_checks++;
    if (d0 !== 22) begin n_errors++; $display("FAIL b2b_done0: got %0d expected 22", d0); end
    n_checks++;
    if (d1 !== 45) begin n_errors++; $display("FAIL b2b_done1: got %0d expected 45", d1); end
    n_checks++;
    if (d2 !== 68) begin n_errors++; $display("FAIL b2b_done2: got %0d expected 68", d2); end
    n_checks++;
    if (r1 !== PT_B) begin n_errors++; $display("FAIL b2b_result1: got %h expected %h", r1, PT_B); end
    n_checks++;
    if (r2 !== PT_B) begin n_errors++; $display("FAIL b2b_result2: got %h expected %h", r2, PT_B); end
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [127:0] k, c, exp, got;
    logic busy1;
    int first, nd;
    for (int n = 0; n < 5; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      exp = model_decrypt(k, c);
      write_key(k);
      write_block(c);
      run_dec(busy1, first, nd);
      read_block(got);
      n_checks++;
      if (first !== 22) begin n_errors++; $display("FAIL rand%0d_latency: got %0d expected 22", n, first); end
      n_checks++;
      if (got !== exp) begin n_errors++; $display("FAIL rand%0d_result: got %h expected %h", n, got, exp); end
    end
  endtask

  task automatic test_same_cycle_write();
    logic [127:0] k, c, c2, exp, got;
    logic [7:0] d;
    logic busy1;
    int a, first, nd;
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    a = $urandom_range(0, 15);
    d = c[127 - 8*a -: 8] ^ 8'ha5;
    c2 = c;
    c2[127 - 8*a -: 8] = d;
    write_key(k);
    write_block(c);
    iDEC = 1'b1; iWR = 1'b1; iADDR = a[3:0]; iDATA = d;
    tick();
    iDEC = 1'b0; iWR = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oDONE) nd++;
    end
    read_block(got);
    exp = model_decrypt(k, c);
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL samecyc_old_block: got %h expected %h", got, exp); end
    run_dec(busy1, first, nd);
    read_block(got);
    exp = model_decrypt(k, c2);
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL samecyc_new_block: got %h expected %h", got, exp); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    iRST = 1'b1; iDATA = 8'h00; iADDR = 4'd0;
    iWR = 1'b0; iKWR = 1'b0; iRD = 1'b0; iDEC = 1'b0;
    init_tables();
    test_reset();
    test_vector("fips_b", KEY_B, CT_B, PT_B);
    test_vector("fips_c1", KEY_C, CT_C, PT_C);
    test_isolation();
    test_reset_midop();
    test_back_to_back();
    test_random();
    test_same_cycle_write();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
